store_queue: RTL and testbench

In-order store queue in the MEM unit, directly downstream of the address generator. It captures each store's address, pre-aligned data and ROB id. It holds stores until the ROB commits them, then drains committed stores to data memory through a valid/ready handshake. It also answers store-to-load forwarding lookups for the load path.

---
 rtl/store_queue.sv | 175 +++++++++++++++++
 tb/tb_store_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue with commit, memory drain and store-to-load forwarding (optional feature macro: SQ_FORWARD_EN)
module store_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  store_valid,
    input  logic [ADDR_WIDTH-1:0] store_waddr,
    input  logic [DATA_WIDTH-1:0] store_wdata,
    input  logic [2:0]            store_funct3,
    input  logic [ROB_WIDTH-1:0]  store_rob_id,
    output logic                  sq_full,
    output logic                  sq_empty,
    input  logic                  commit_valid,
    input  logic [ROB_WIDTH-1:0]  commit_rob_id,
    input  logic                  flush,
    output logic                  mem_wvalid,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_wready,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_raddr,
    input  logic [2:0]            load_funct3,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_conflict
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;

    // Byte-enable pattern for a naturally aligned access of the given size.
    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   strb_of = 4'b0001 << off;
            2'b01:   strb_of = off[1] ? 4'b1100 : 4'b0011;
            default: strb_of = 4'b1111;
        endcase
    endfunction

    logic [PTR_W-1:0]      head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [WA_W-1:0]       ent_addr_q [DEPTH];
    logic [WA_W-1:0]       ent_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_d [DEPTH];
    logic [3:0]            ent_strb_q [DEPTH];
    logic [3:0]            ent_strb_d [DEPTH];
    logic [ROB_WIDTH-1:0]  ent_rob_q  [DEPTH];
    logic [ROB_WIDTH-1:0]  ent_rob_d  [DEPTH];

    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;
    logic [PTR_W-1:0] count;
    logic             alloc, commit_ok, drain;

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign count    = tail_q - head_q;

    assign sq_full  = (count == PTR_W'(DEPTH));
    assign sq_empty = (tail_q == head_q);

    assign alloc     = store_valid && !sq_full && !flush;
    assign commit_ok = commit_valid && (cmt_q != tail_q) && (ent_rob_q[cmt_idx] == commit_rob_id);

    // The oldest committed entry is presented; payload is zeroed while idle so reset shows zeros.
    assign mem_wvalid = (head_q != cmt_q);
    assign drain      = mem_wvalid && mem_wready;
    assign mem_waddr  = mem_wvalid ? {ent_addr_q[head_idx], 2'b00} : '0;
    assign mem_wdata  = mem_wvalid ? ent_data_q[head_idx] : '0;
    assign mem_wstrb  = mem_wvalid ? ent_strb_q[head_idx] : '0;

    // Next pointers: flush rolls tail back to the post-commit cmt, dropping speculative stores.
    always_comb begin
        head_d = drain ? head_q + PTR_W'(1) : head_q;
        cmt_d  = commit_ok ? cmt_q + PTR_W'(1) : cmt_q;
        tail_d = alloc ? tail_q + PTR_W'(1) : tail_q;
        if (flush) begin
            tail_d = cmt_d;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // Entry write at tail on allocation.
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_strb_d = ent_strb_q;
        ent_rob_d  = ent_rob_q;
        if (alloc) begin
            ent_addr_d[tail_idx] = store_waddr[ADDR_WIDTH-1:2];
            ent_data_d[tail_idx] = store_wdata;
            ent_strb_d[tail_idx] = strb_of(store_funct3[1:0], store_waddr[1:0]);
            ent_rob_d[tail_idx]  = store_rob_id;
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset is needed.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_strb_q <= ent_strb_d;
        ent_rob_q  <= ent_rob_d;
    end

    logic [IDX_W-1:0] slot;
    logic             unused_bits;

`ifdef SQ_FORWARD_EN
    logic [3:0]            lmask, sel_strb;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  match;

    assign unused_bits = ^{store_funct3[2], load_funct3[2]};

    // Scan oldest to youngest so the last matching entry (youngest) wins.
    always_comb begin
        lmask        = strb_of(load_funct3[1:0], load_raddr[1:0]);
        match        = 1'b0;
        sel_strb     = '0;
        sel_data     = '0;
        slot         = '0;
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_data     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_idx + IDX_W'(k);
            if ((PTR_W'(k) < count) && (ent_addr_q[slot] == load_raddr[ADDR_WIDTH-1:2])) begin
                match    = 1'b1;
                sel_strb = ent_strb_q[slot];
                sel_data = ent_data_q[slot];
            end
        end
        if (load_valid && match) begin
            fwd_hit      = ((sel_strb & lmask) == lmask);
            fwd_conflict = !fwd_hit && ((sel_strb & lmask) != 4'b0000);
            fwd_data     = sel_data;
        end
    end
`else
    assign unused_bits = ^{store_funct3[2], load_funct3, load_raddr[1:0]};

    // Any word-address match forces a replay; no data is ever forwarded.
    always_comb begin
        slot         = '0;
        fwd_hit      = 1'b0;
        fwd_data     = '0;
        fwd_conflict = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_idx + IDX_W'(k);
            if ((PTR_W'(k) < count) && (ent_addr_q[slot] == load_raddr[ADDR_WIDTH-1:2])) begin
                fwd_conflict = load_valid;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_valid;
    logic [31:0] store_waddr;
    logic [31:0] store_wdata;
    logic [2:0]  store_funct3;
    logic [4:0]  store_rob_id;
    logic        sq_full, sq_empty;
    logic        commit_valid;
    logic [4:0]  commit_rob_id;
    logic        flush;
    logic        mem_wvalid;
    logic [31:0] mem_waddr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wready;
    logic        load_valid;
    logic [31:0] load_raddr;
    logic [2:0]  load_funct3;
    logic        fwd_hit, fwd_conflict;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .store_valid(store_valid), .store_waddr(store_waddr), .store_wdata(store_wdata),
        .store_funct3(store_funct3), .store_rob_id(store_rob_id),
        .sq_full(sq_full), .sq_empty(sq_empty),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .flush(flush),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wready(mem_wready),
        .load_valid(load_valid), .load_raddr(load_raddr), .load_funct3(load_funct3),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic [4:0] rob);
        store_valid  = 1'b1;
        store_waddr  = a;
        store_wdata  = d;
        store_funct3 = f3;
        store_rob_id = rob;
        tick();
        store_valid  = 1'b0;
    endtask

    task automatic do_commit(input logic [4:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        tick();
        commit_valid  = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3);
        load_valid  = 1'b1;
        load_raddr  = a;
        load_funct3 = f3;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        store_valid = 1'b0; store_waddr = '0; store_wdata = '0; store_funct3 = '0; store_rob_id = '0;
        commit_valid = 1'b0; commit_rob_id = '0; flush = 1'b0; mem_wready = 1'b0;
        load_valid = 1'b0; load_raddr = '0; load_funct3 = '0;
        #12;
        check("rst_empty", 32'(sq_empty), 32'd1);
        check("rst_full", 32'(sq_full), 32'd0);
        check("rst_wvalid", 32'(mem_wvalid), 32'd0);
        check("rst_waddr", mem_waddr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_fwd", {29'd0, fwd_hit, fwd_conflict, |fwd_data}, 32'd0);
        rst_n = 1'b1;

        // Single store: allocate, commit, drain.
        do_store(32'h100, 32'hDEADBEEF, 3'b010, 5'd3);
        check("t1_empty_after_alloc", 32'(sq_empty), 32'd0);
        check("t1_wvalid_before_commit", 32'(mem_wvalid), 32'd0);
        do_commit(5'd3);
        check("t1_wvalid", 32'(mem_wvalid), 32'd1);
        check("t1_waddr", mem_waddr, 32'h100);
        check("t1_wdata", mem_wdata, 32'hDEADBEEF);
        check("t1_wstrb", 32'(mem_wstrb), 32'hF);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("t1_empty_after_drain", 32'(sq_empty), 32'd1);
        check("t1_wvalid_after_drain", 32'(mem_wvalid), 32'd0);

        // Mismatched rob id commit is ignored.
        do_store(32'h300, 32'h55, 3'b010, 5'd9);
        do_commit(5'd8);
        check("mm_wvalid", 32'(mem_wvalid), 32'd0);
        do_commit(5'd9);
        check("mm_wvalid_good", 32'(mem_wvalid), 32'd1);
        check("mm_waddr", mem_waddr, 32'h300);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("mm_empty", 32'(sq_empty), 32'd1);

        // Fill to full, drop a ninth, then commit and drain in order across the wrap.
        for (int i = 0; i < 8; i++) begin
            do_store(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 5'(10 + i));
        end
        check("fill_full", 32'(sq_full), 32'd1);
        do_store(32'h2000, 32'hFF, 3'b010, 5'd20);
        check("fill_full_after_drop", 32'(sq_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_commit(5'(10 + i));
        end
        mem_wready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_wvalid", i), 32'(mem_wvalid), 32'd1);
            check($sformatf("drain%0d_waddr", i), mem_waddr, 32'h1000 + 32'(4 * i));
            check($sformatf("drain%0d_wdata", i), mem_wdata, 32'hA0 + 32'(i));
            tick();
        end
        mem_wready = 1'b0;
        check("fill_empty", 32'(sq_empty), 32'd1);
        check("fill_wvalid_end", 32'(mem_wvalid), 32'd0);

        // Flush keeps committed stores and suppresses a same-cycle allocation.
        for (int i = 0; i < 4; i++) begin
            do_store(32'h500 + 32'(4 * i), 32'hC0 + 32'(i), 3'b010, 5'(1 + i));
        end
        do_commit(5'd1);
        do_commit(5'd2);
        flush = 1'b1;
        do_store(32'h600, 32'hEE, 3'b010, 5'd6);
        flush = 1'b0;
        check("fl_not_empty", 32'(sq_empty), 32'd0);
        mem_wready = 1'b1;
        check("fl_waddr0", mem_waddr, 32'h500);
        tick();
        check("fl_waddr1", mem_waddr, 32'h504);
        tick();
        mem_wready = 1'b0;
        check("fl_wvalid_end", 32'(mem_wvalid), 32'd0);
        check("fl_empty_end", 32'(sq_empty), 32'd1);

        // Forwarding.
        do_store(32'h203, 32'hAB000000, 3'b000, 5'd5);
        do_load(32'h203, 3'b000);
`ifdef SQ_FORWARD_EN
        check("lb_hit", 32'(fwd_hit), 32'd1);
        check("lb_conflict", 32'(fwd_conflict), 32'd0);
        check("lb_data", fwd_data, 32'hAB000000);
`else
        check("lb_hit", 32'(fwd_hit), 32'd0);
        check("lb_conflict", 32'(fwd_conflict), 32'd1);
        check("lb_data", fwd_data, 32'd0);
`endif
        do_load(32'h200, 3'b010);
        check("lw_conflict", 32'(fwd_conflict), 32'd1);
        check("lw_hit", 32'(fwd_hit), 32'd0);
        do_load(32'h204, 3'b010);
        check("nomatch", {30'd0, fwd_hit, fwd_conflict}, 32'd0);
        check("nomatch_data", fwd_data, 32'd0);
        load_valid = 1'b0;
        load_raddr = 32'h203;
        load_funct3 = 3'b000;
        #1;
        check("ld_idle", {29'd0, fwd_hit, fwd_conflict, |fwd_data}, 32'd0);

        // A store allocated in the same cycle is not yet visible.
        store_valid  = 1'b1;
        store_waddr  = 32'h40;
        store_wdata  = 32'h11;
        store_funct3 = 3'b010;
        store_rob_id = 5'd6;
        do_load(32'h40, 3'b010);
        check("same_cycle", {30'd0, fwd_hit, fwd_conflict}, 32'd0);
        tick();
        store_valid = 1'b0;
        load_valid  = 1'b0;
        do_store(32'h40, 32'h22, 3'b010, 5'd7);
        do_load(32'h40, 3'b010);
`ifdef SQ_FORWARD_EN
        check("young_hit", 32'(fwd_hit), 32'd1);
        check("young_data", fwd_data, 32'h22);
`else
        check("young_hit", 32'(fwd_hit), 32'd0);
        check("young_conflict", 32'(fwd_conflict), 32'd1);
`endif
        load_valid = 1'b0;

        // Commit the byte store and check its strobe on the memory side, then flush the rest.
        commit_valid  = 1'b1;
        commit_rob_id = 5'd5;
        flush         = 1'b1;
        tick();
        commit_valid  = 1'b0;
        flush         = 1'b0;
        check("sb_waddr", mem_waddr, 32'h200);
        check("sb_wstrb", 32'(mem_wstrb), 32'h8);
        check("sb_wdata", mem_wdata, 32'hAB000000);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("final_empty", 32'(sq_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
